// File: rtl/hack_fetch_unit.sv
// Instruction fetch for the HACK CPU: one outstanding ROM request, a small
// shift-register FIFO toward decode, and redirect/flush handling for taken jumps.
module hack_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;
  logic [15:0]            addr_q, addr_d;
  logic [15:0]            fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DEPTH-1:0][31:0] entry_q, entry_d;

  logic          pop;
  logic          push;
  logic          space;
  logic [CW-1:0] wr_idx;
  logic [15:0]   addr_inc;
  logic [15:0]   drop_tgt;

  // FIFO bookkeeping: entry 0 is always the head, so head outputs come straight from flops.
  always_comb begin
    pop      = valid_q & instr_ready;
    push     = (state_q == ST_WAIT) & imem_ack & ~redirect;
    wr_idx   = count_q - CW'(pop);
    count_d  = redirect ? '0 : (wr_idx + CW'(push));
    space    = count_d < CW'(DEPTH);
    valid_d  = (count_d != '0);
    addr_inc = addr_q + 16'd1;

    entry_d = pop ? (entry_q >> 32) : entry_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CW'(i))) begin
        entry_d[i] = {addr_q, imem_rdata};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    drop_tgt   = redirect ? redirect_addr : fetch_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_addr;
        end
        if (space) begin
          state_d = ST_WAIT;
          addr_d  = redirect ? redirect_addr : fetch_pc_q;
        end
      end

      ST_WAIT: begin
        if (redirect && imem_ack) begin
          // Response is thrown away; the next request goes straight to the target.
          fetch_pc_d = redirect_addr;
          addr_d     = redirect_addr;
        end else if (redirect) begin
          fetch_pc_d = redirect_addr;
          state_d    = ST_DROP;
        end else if (imem_ack) begin
          fetch_pc_d = addr_inc;
          if (space) begin
            addr_d = addr_inc;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        if (imem_ack) begin
          fetch_pc_d = drop_tgt;
          if (space) begin
            state_d = ST_WAIT;
            addr_d  = drop_tgt;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_addr;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_VECTOR;
      fetch_pc_q <= RESET_VECTOR;
      count_q    <= '0;
      valid_q    <= 1'b0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      entry_q    <= entry_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = entry_q[0][15:0];
  assign instr_pc    = entry_q[0][31:16];

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Randomized bench for hack_fetch_unit: ROM responder with random latency, and a
// scoreboard holding the expected program-order instruction stream.
module tb_hack_fetch_unit;

  localparam logic [15:0] RV    = 16'hFFFC;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int rom_max_lat = 0;

  // Expected instruction addresses in program order from the current fetch start point.
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  hack_fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready)
  );

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic load_stream(input logic [15:0] base);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(base + 16'(i));
  endtask

  task automatic check_reset_outputs();
    check("rst_req",   32'(imem_req),    32'(0));
    check("rst_addr",  32'(imem_addr),   32'(RV));
    check("rst_valid", 32'(instr_valid), 32'(0));
    check("rst_instr", 32'(instr),       32'(0));
    check("rst_pc",    32'(instr_pc),    32'(0));
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_addr = 16'h0100;
        1:       redirect_addr = 16'hFFFE;
        default: redirect_addr = 16'($urandom);
      endcase
    end
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    instr_ready = 1'b1;
  endtask

  // ROM: returns rom_word(addr) after a random number of wait cycles; stray acks when idle.
  initial begin : rom
    int lat;
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        imem_ack = 1'b0;
        lat = 0;
      end else if (imem_req) begin
        if (lat == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = rom_word(imem_addr);
          lat        = int'($urandom_range(0, rom_max_lat));
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'($urandom);
          lat--;
        end
      end else begin
        imem_ack   = ($urandom_range(0, 3) == 0);
        imem_rdata = 16'($urandom);
      end
    end
  end

  initial begin : monitor
    logic        prev_req, prev_ack, prev_redir, prev_hold;
    logic [15:0] prev_addr, prev_pc, prev_instr, e;
    int          stall;
    prev_req = 0; prev_ack = 0; prev_redir = 0; prev_hold = 0;
    prev_addr = 0; prev_pc = 0; prev_instr = 0; stall = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        load_stream(RV);
        prev_req = 0; prev_ack = 0; prev_redir = 0; prev_hold = 0; stall = 0;
        continue;
      end
      if (prev_req && !prev_ack) begin
        check("req_hold",  32'(imem_req),  32'(1));
        check("addr_hold", 32'(imem_addr), 32'(prev_addr));
      end
      if (prev_redir) begin
        check("flush_valid", 32'(instr_valid), 32'(0));
      end else if (prev_hold) begin
        check("hold_valid", 32'(instr_valid), 32'(1));
        check("hold_pc",    32'(instr_pc),    32'(prev_pc));
        check("hold_instr", 32'(instr),       32'(prev_instr));
      end
      if (instr_valid && instr_ready) begin
        pops++;
        stall = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream: pop of pc %h with no expected entry", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(e));
          check("instr",    32'(instr),    32'(rom_word(e)));
        end
      end else if (instr_ready && !redirect) begin
        stall++;
        if (stall > 40) begin
          check("progress", 32'(stall), 32'(40));
          stall = 0;
        end
      end
      if (redirect) begin
        load_stream(redirect_addr);
        stall = 0;
      end
      prev_req   = imem_req;
      prev_ack   = imem_req && imem_ack;
      prev_redir = redirect;
      prev_hold  = instr_valid && !instr_ready;
      prev_addr  = imem_addr;
      prev_pc    = instr_pc;
      prev_instr = instr;
    end
  end

  initial begin : stim
    int w;
    reset_n = 1'b0;
    instr_ready = 1'b1;
    redirect = 1'b0;
    rom_max_lat = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    #1 reset_n = 1'b1;

    // Zero-wait ROM: first request at RV, then one instruction every cycle.
    @(negedge clk);
    check("first_req",   32'(imem_req),    32'(1));
    check("first_addr",  32'(imem_addr),   32'(RV));
    check("first_valid", 32'(instr_valid), 32'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(instr_valid), 32'(1));
    end

    // Decode stalls: FIFO fills and fetch goes idle.
    @(posedge clk);
    #1 instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("full_req",   32'(imem_req),    32'(0));
    check("full_valid", 32'(instr_valid), 32'(1));
    @(posedge clk);
    #1 instr_ready = 1'b1;
    repeat (4) @(negedge clk);

    rom_max_lat = 3;
    random_phase(3000);

    // Asynchronous reset while a request is waiting on the ROM.
    w = 0;
    @(negedge clk);
    while (!(imem_req && !imem_ack) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("reach_wait", 32'(imem_req && !imem_ack), 32'(1));
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    #2 reset_n = 1'b1;
    w = 0;
    @(negedge clk);
    while (!imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("restart_req",  32'(imem_req),  32'(1));
    check("restart_addr", 32'(imem_addr), 32'(RV));

    random_phase(800);
    repeat (20) @(negedge clk);
    check("pops_total", 32'(pops > 300), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
